// File: rtl/instruction_loader_pkg.sv
// Shared definitions for the boot-time instruction loader: widths and FSM state encoding.
package instruction_loader_pkg;

  localparam int ADDR_WIDTH     = 10;
  localparam int DATA_WIDTH     = 32;
  localparam int BYTES_PER_WORD = 4;

  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_COUNT_HI = 3'd1;
  localparam logic [2:0] S_COUNT_LO = 3'd2;
  localparam logic [2:0] S_WORD     = 3'd3;
  localparam logic [2:0] S_CHECK    = 3'd4;
  localparam logic [2:0] S_DONE     = 3'd5;
  localparam logic [2:0] S_ERROR    = 3'd6;

  function automatic logic is_active(input logic [2:0] s);
    return (s == S_COUNT_HI) || (s == S_COUNT_LO) || (s == S_WORD) || (s == S_CHECK);
  endfunction

endpackage

// File: rtl/instruction_loader_word_assembler.sv
// Packs accepted bytes MSB first into a word; 'complete' flags the 4th byte combinationally.
module instruction_loader_word_assembler
  import instruction_loader_pkg::*;
(
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  clear,
  input  logic                  accept,
  input  logic [7:0]            byte_in,
  output logic [DATA_WIDTH-1:0] word,
  output logic                  complete
);

  localparam int IDX_W = $clog2(BYTES_PER_WORD);

  logic [DATA_WIDTH-9:0] shift;
  logic [IDX_W-1:0]      index;

  always_ff @(posedge clock) begin
    if (reset || clear) begin
      shift <= '0;
      index <= '0;
    end else if (accept) begin
      shift <= {shift[DATA_WIDTH-17:0], byte_in};
      index <= index + 1'b1;
    end
  end

  // The word is presented on the same cycle its last byte arrives.
  assign word     = {shift, byte_in};
  assign complete = accept && (index == IDX_W'(BYTES_PER_WORD - 1));

endmodule

// File: rtl/instruction_loader.sv
// Loads a counted, XOR-checked byte stream into instruction memory and holds the CPU until done.
module instruction_loader #(
  parameter int ADDR_WIDTH = instruction_loader_pkg::ADDR_WIDTH,
  parameter int DATA_WIDTH = instruction_loader_pkg::DATA_WIDTH,
  parameter int DEPTH      = 1024
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  start,
  input  logic [7:0]            byte_in,
  input  logic                  byte_valid,
  output logic                  byte_ready,
  output logic                  write_enable,
  output logic [ADDR_WIDTH-1:0] write_address,
  output logic [DATA_WIDTH-1:0] write_data,
  output logic                  loading,
  output logic                  done,
  output logic                  error,
  output logic                  cpu_hold
);
  import instruction_loader_pkg::*;

  logic [2:0]            state;
  logic [7:0]            count_hi;
  logic [7:0]            checksum;
  logic [15:0]           word_target;
  logic [15:0]           words_written;
  logic [ADDR_WIDTH-1:0] address;
  logic [15:0]           count_value;
  logic                  accept;
  logic                  word_complete;
  logic [DATA_WIDTH-1:0] assembled;

  assign loading     = is_active(state);
  assign byte_ready  = loading;
  assign done        = (state == S_DONE);
  assign error       = (state == S_ERROR);
  assign cpu_hold    = !done;
  assign accept      = byte_valid && byte_ready;
  assign count_value = {count_hi, byte_in};

  instruction_loader_word_assembler u_word_assembler (
    .clock    (clock),
    .reset    (reset),
    .clear    (start && !loading),
    .accept   (accept && (state == S_WORD)),
    .byte_in  (byte_in),
    .word     (assembled),
    .complete (word_complete)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      state         <= S_IDLE;
      write_enable  <= 1'b0;
      write_address <= '0;
      write_data    <= '0;
      address       <= '0;
      words_written <= '0;
      word_target   <= '0;
      count_hi      <= '0;
      checksum      <= '0;
    end else begin
      // Strobe, address and data are registered together one cycle after the word's last byte.
      write_enable <= word_complete;
      if (word_complete) begin
        write_data    <= assembled;
        write_address <= address;
        address       <= address + 1'b1;
        words_written <= words_written + 16'd1;
      end
      if (accept && (state != S_CHECK))
        checksum <= checksum ^ byte_in;

      case (state)
        S_IDLE, S_DONE, S_ERROR: begin
          if (start) begin
            state         <= S_COUNT_HI;
            address       <= '0;
            words_written <= '0;
            checksum      <= '0;
          end
        end
        S_COUNT_HI: begin
          if (accept) begin
            count_hi <= byte_in;
            state    <= S_COUNT_LO;
          end
        end
        S_COUNT_LO: begin
          if (accept) begin
            word_target <= count_value;
            if (int'(count_value) > DEPTH) state <= S_ERROR;
            else if (count_value == 16'd0) state <= S_CHECK;
            else                           state <= S_WORD;
          end
        end
        S_WORD: begin
          if (word_complete && ((words_written + 16'd1) == word_target))
            state <= S_CHECK;
        end
        S_CHECK: begin
          if (accept)
            state <= (byte_in == checksum) ? S_DONE : S_ERROR;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
